// File: rtl/jcs_bus_sequencer.sv
// jcs_bus_sequencer
//   Automatic bus-transfer controller. Queues "move SRC -> DST" requests and
//   plays each one out on the ena/set decoder codes as a three-phase transfer:
//   enable (SETUP cycles), enable+set (SET_W cycles), hold (HOLD cycles).
//   At least one bus-idle cycle always separates consecutive transfers.
//
// Ports
//   CLK        system clock, rising edge
//   RESETN     asynchronous active-low reset
//   REQ_VALID  request present
//   REQ_READY  FIFO not full (registered, post-edge occupancy)
//   REQ_SRC    component code to enable onto the bus
//   REQ_DST    component code to set from the bus
//   ENAS       enable code to the ena decoder (0 = none)
//   SETS       set code to the set decoder (0 = none)
//   BUSY       FSM outside IDLE or FIFO non-empty
//   DONE       one-cycle pulse when a transfer completes
//   ERR        one-cycle pulse when an invalid request is discarded
//   COUNT      completed-transfer counter, wraps 255 -> 0
module jcs_bus_sequencer #(
  parameter int unsigned CODE_W = 4,
  parameter int unsigned LAST   = 7,
  parameter int unsigned SETUP  = 1,
  parameter int unsigned SET_W  = 2,
  parameter int unsigned HOLD   = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [CODE_W-1:0] REQ_SRC,
  input  logic [CODE_W-1:0] REQ_DST,
  output logic [CODE_W-1:0] ENAS,
  output logic [CODE_W-1:0] SETS,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [7:0]        COUNT
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PMAX = (SETUP > SET_W) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                                 : ((SET_W > HOLD) ? SET_W : HOLD);
  localparam int unsigned PW   = (PMAX < 2) ? 1 : $clog2(PMAX);

  typedef enum logic [1:0] {IDLE, ENA, SET, HLD} state_t;

  // Request FIFO
  logic [2*CODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         occ, occ_next;
  logic                push, pop;
  logic [CODE_W-1:0]   head_src, head_dst;
  logic                head_ok;

  // FSM
  state_t            state, state_next;
  logic [PW-1:0]     phase, phase_next;
  logic [CODE_W-1:0] src_q, dst_q, src_next, dst_next;
  logic              done_next, err_next;
  logic [CODE_W-1:0] enas_next, sets_next;

  assign push = REQ_VALID & REQ_READY;
  assign pop  = (state == IDLE) && (occ != '0);

  assign occ_next = occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign head_src = mem[rd_ptr][2*CODE_W-1:CODE_W];
  assign head_dst = mem[rd_ptr][CODE_W-1:0];
  assign head_ok  = (head_src != '0) && (head_src <= CODE_W'(LAST)) &&
                    (head_dst != '0) && (head_dst <= CODE_W'(LAST)) &&
                    (head_src != head_dst);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {REQ_SRC, REQ_DST};
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      REQ_READY <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ       <= occ_next;
      REQ_READY <= (occ_next != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
      phase <= '0;
      src_q <= '0;
      dst_q <= '0;
      ENAS  <= '0;
      SETS  <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      COUNT <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
      src_q <= src_next;
      dst_q <= dst_next;
      ENAS  <= enas_next;
      SETS  <= sets_next;
      BUSY  <= (state_next != IDLE) || (occ_next != '0);
      DONE  <= done_next;
      ERR   <= err_next;
      COUNT <= COUNT + 8'(done_next);
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase + 1'b1;
    src_next   = src_q;
    dst_next   = dst_q;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        phase_next = '0;
        if (pop) begin
          if (head_ok) begin
            state_next = ENA;
            src_next   = head_src;
            dst_next   = head_dst;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ENA: begin
        if (phase == PW'(SETUP - 1)) begin
          state_next = SET;
          phase_next = '0;
        end
      end
      SET: begin
        if (phase == PW'(SET_W - 1)) begin
          state_next = HLD;
          phase_next = '0;
        end
      end
      HLD: begin
        if (phase == PW'(HOLD - 1)) begin
          state_next = IDLE;
          phase_next = '0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Codes are registered from the next state so ENAS/SETS change on the
  // same edge as the phase transition rather than one cycle later.
  always_comb begin
    enas_next = '0;
    sets_next = '0;
    if (state_next != IDLE) enas_next = src_next;
    if (state_next == SET)  sets_next = dst_next;
  end

endmodule

// File: tb/tb_jcs_bus_sequencer.sv
module tb_jcs_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rv;
  logic [3:0] rs   [2];
  logic [3:0] rd   [2];
  logic       rdy  [2];
  logic [3:0] enas [2];
  logic [3:0] sets [2];
  logic       busy [2];
  logic       done [2];
  logic       err  [2];
  logic [7:0] count[2];

  always #5 clk = ~clk;

  jcs_bus_sequencer dut0 (
    .CLK(clk), .RESETN(rst_n), .REQ_VALID(rv[0]), .REQ_READY(rdy[0]),
    .REQ_SRC(rs[0]), .REQ_DST(rd[0]), .ENAS(enas[0]), .SETS(sets[0]),
    .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0]), .COUNT(count[0])
  );

  jcs_bus_sequencer #(.SETUP(2), .SET_W(1), .HOLD(3)) dut1 (
    .CLK(clk), .RESETN(rst_n), .REQ_VALID(rv[1]), .REQ_READY(rdy[1]),
    .REQ_SRC(rs[1]), .REQ_DST(rd[1]), .ENAS(enas[1]), .SETS(sets[1]),
    .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1]), .COUNT(count[1])
  );

  typedef struct {
    logic       is_err;
    logic [3:0] src;
    logic [3:0] dst;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cnt_exp[2];
  // Expected phase shape per instance: ENAS width, SETS width, SETS offset.
  int   exp_ena [2] = '{4, 6};
  int   exp_set [2] = '{2, 1};
  int   exp_off [2] = '{1, 2};
  logic mark_rise = 1'b0;
  longint acc_t, rise_t, done_t;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int id);
    if (id == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void qpush(input int id, input exp_t x);
    if (id == 0) q0.push_back(x);
    else q1.push_back(x);
  endfunction

  task automatic mon(input int id);
    logic       in_x = 1'b0;
    logic [3:0] src_c = '0, dst_c = '0, prev_e = '0;
    int         ena_len = 0, set_len = 0, set_off = -1;
    exp_t       x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_x = 1'b0; prev_e = '0; cnt_exp[id] = 0;
        continue;
      end
      if (sets[id] != 0) begin
        check("inv_sets_needs_enas", int'(enas[id] != 0), 1);
        check("inv_enas_stable", enas[id], prev_e);
      end
      if (enas[id] != 0) begin
        if (!in_x) begin
          in_x = 1'b1; src_c = enas[id]; dst_c = '0;
          ena_len = 0; set_len = 0; set_off = -1;
          if (id == 0 && mark_rise) begin
            rise_t = $time; mark_rise = 1'b0;
          end
        end
        if (enas[id] != src_c) check("enas_changed", enas[id], src_c);
        if (sets[id] != 0) begin
          if (set_off < 0) set_off = ena_len;
          dst_c = sets[id];
          set_len++;
        end
        ena_len++;
      end else if (in_x && !done[id]) begin
        check("enas_dropped_without_done", 0, 1);
        in_x = 1'b0;
      end
      if (done[id]) begin
        if (id == 0) done_t = $time;
        if (qsize(id) == 0) check("done_unexpected", 1, 0);
        else begin
          x = qpop(id);
          check("done_is_valid_req", x.is_err, 0);
          check("done_src", src_c, x.src);
          check("done_dst", dst_c, x.dst);
          check("enas_width", ena_len, exp_ena[id]);
          check("sets_width", set_len, exp_set[id]);
          check("sets_offset", set_off, exp_off[id]);
        end
        check("done_bus_idle", enas[id], 0);
        cnt_exp[id] = (cnt_exp[id] + 1) % 256;
        check("count", count[id], cnt_exp[id]);
        check("busy_at_done", busy[id], int'(qsize(id) != 0));
        in_x = 1'b0;
      end
      if (err[id]) begin
        if (qsize(id) == 0) check("err_unexpected", 1, 0);
        else begin
          x = qpop(id);
          check("err_is_invalid_req", x.is_err, 1);
        end
        check("err_bus_idle", enas[id], 0);
        check("err_count_held", count[id], cnt_exp[id]);
        check("busy_at_err", busy[id], int'(qsize(id) != 0));
      end
      prev_e = enas[id];
    end
  endtask

  task automatic push(input int id, input logic [3:0] s, input logic [3:0] d);
    exp_t x;
    int   w = 0;
    x.is_err = !(s >= 1 && s <= 7 && d >= 1 && d <= 7 && s != d);
    x.src = s;
    x.dst = d;
    @(negedge clk);
    while (!rdy[id] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!rdy[id]) begin
      check("push_ready_timeout", 0, 1);
      rv[id] = 1'b0;
      return;
    end
    rv[id] = 1'b1; rs[id] = s; rd[id] = d;
    @(posedge clk);
    acc_t = $time;
    qpush(id, x);
  endtask

  task automatic stop_push(input int id);
    @(negedge clk);
    rv[id] = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((busy[id] || qsize(id) != 0 || enas[id] != 0) && w < 3000);
    if (busy[id] || qsize(id) != 0) check("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rv = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] s, d;
    int w;
    rst_n = 1'b0;
    rv = '0;
    rs = '{4'd0, 4'd0};
    rd = '{4'd0, 4'd0};
    fork
      mon(0);
      mon(1);
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_enas", enas[0], 0);
    check("rst_sets", sets[0], 0);
    check("rst_done", done[0], 0);
    check("rst_err", err[0], 0);
    check("rst_count", count[0], 0);
    check("rst_busy", busy[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", rdy[0], 1);

    // Single transfer DATA -> R0, absolute latency from the accept edge
    mark_rise = 1'b1;
    push(0, 4'd1, 4'd2);
    stop_push(0);
    wait_idle(0);
    check("first_enas_latency", int'(rise_t - acc_t), 15);
    check("first_done_latency", int'(done_t - acc_t), 55);
    check("count_after_one", count[0], 1);

    // Five back-to-back requests with REQ_VALID held high
    do_reset();
    mark_rise = 1'b1;
    push(0, 4'd1, 4'd2);
    push(0, 4'd2, 4'd3);
    push(0, 4'd3, 4'd4);
    push(0, 4'd4, 4'd5);
    push(0, 4'd5, 4'd6);
    stop_push(0);
    check("ready_low_when_full", rdy[0], 0);
    wait_idle(0);
    check("b2b_span", int'(done_t - rise_t), 240);
    check("count_after_five", count[0], 5);

    // Valid / invalid mix including back-to-back invalid entries
    do_reset();
    push(0, 4'd1, 4'd2);
    push(0, 4'd3, 4'd3);
    push(0, 4'd2, 4'd4);
    push(0, 4'd0, 4'd2);
    push(0, 4'd8, 4'd1);
    push(0, 4'd6, 4'd7);
    stop_push(0);
    wait_idle(0);
    check("count_valid_only", count[0], 3);

    // Reset in the middle of the SET phase with entries still queued
    do_reset();
    push(0, 4'd4, 4'd5);
    push(0, 4'd5, 4'd6);
    push(0, 4'd6, 4'd7);
    stop_push(0);
    w = 0;
    while (sets[0] == 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("reached_set_phase", int'(sets[0] != 0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_enas", enas[0], 0);
    check("async_rst_sets", sets[0], 0);
    q0.delete();
    repeat (2) @(negedge clk);
    check("rst_mid_done", done[0], 0);
    check("rst_mid_count", count[0], 0);
    check("rst_mid_busy", busy[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", rdy[0], 1);
    repeat (10) @(negedge clk);
    check("queue_flushed_enas", enas[0], 0);
    check("queue_flushed_busy", busy[0], 0);

    // 256 transfers: COUNT wraps to 0 on the last DONE
    for (int i = 0; i < 256; i++) begin
      s = 4'(1 + (i % 7));
      d = 4'(1 + ((i + 3) % 7));
      push(0, s, d);
    end
    stop_push(0);
    wait_idle(0);
    check("count_wrap", count[0], 0);

    // Alternate phase lengths on the second instance
    push(1, 4'd2, 4'd5);
    push(1, 4'd7, 4'd1);
    push(1, 4'd1, 4'd1);
    stop_push(1);
    wait_idle(1);
    check("sweep_count", count[1], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
